// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller: mtime/mtimecmp timer, external IRQ synchroniser,
// enable gating and a take/handler FSM that drives the one-cycle take pulse and mcause.
module irq_ctrl #(
  parameter int PRESCALE    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mie,
  input  logic        mret,
  input  logic        tmr_wr,
  input  logic [1:0]  tmr_addr,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] tmr_rdata,
  output logic        intrrupt,
  output logic [31:0] csr_mcause_ff,
  output logic [31:0] mip
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [31:0] CAUSE_EXT = {1'b1, 31'd11};
  localparam logic [31:0] CAUSE_TMR = {1'b1, 31'd7};

  typedef enum logic [1:0] {IDLE, TAKE, HANDLER} state_t;

  state_t                 state_q, state_d;
  logic [PS_W-1:0]        prescaler;
  logic                   tick;
  logic [63:0]            mtime, mtimecmp;
  logic                   mtip;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   meip;
  logic                   ext_req, tmr_req, any_req;
  logic                   take_d;
  logic [31:0]            cause_d;
  logic                   unused_bits;

  assign unused_bits = ^{csr_mstatus[31:4], csr_mstatus[2:0],
                         csr_mie[31:12], csr_mie[10:8], csr_mie[6:0]};

  assign tick = (prescaler == PS_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prescaler <= '0;
    else if (tick) prescaler <= '0;
    else prescaler <= prescaler + 1'b1;
  end

  // Any SW write to either mtime half takes precedence over that cycle's increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      if (tmr_wr && tmr_addr == 2'd0) mtime[31:0] <= tmr_wdata;
      else if (tmr_wr && tmr_addr == 2'd1) mtime[63:32] <= tmr_wdata;
      else if (tick) mtime <= mtime + 64'd1;
      if (tmr_wr && tmr_addr == 2'd2) mtimecmp[31:0] <= tmr_wdata;
      if (tmr_wr && tmr_addr == 2'd3) mtimecmp[63:32] <= tmr_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtip    <= 1'b0;
      sync_ff <= '0;
    end else begin
      mtip    <= (mtime >= mtimecmp);
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], ext_irq};
    end
  end

  assign meip    = sync_ff[SYNC_STAGES-1];
  assign mip     = {20'd0, meip, 3'd0, mtip, 7'd0};
  assign ext_req = meip & csr_mie[11];
  assign tmr_req = mtip & csr_mie[7];
  assign any_req = csr_mstatus[3] & (ext_req | tmr_req);

  always_comb begin
    tmr_rdata = 32'd0;
    case (tmr_addr)
      2'd0: tmr_rdata = mtime[31:0];
      2'd1: tmr_rdata = mtime[63:32];
      2'd2: tmr_rdata = mtimecmp[31:0];
      2'd3: tmr_rdata = mtimecmp[63:32];
      default: tmr_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      intrrupt      <= 1'b0;
      csr_mcause_ff <= 32'd0;
    end else begin
      state_q  <= state_d;
      intrrupt <= take_d;
      if (take_d) csr_mcause_ff <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = TAKE;
      TAKE:    state_d = HANDLER;
      HANDLER: if (mret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The take decision is made once in IDLE; the pulse lines up with the TAKE state
  always_comb begin
    take_d  = (state_q == IDLE) && any_req;
    cause_d = ext_req ? CAUSE_EXT : CAUSE_TMR;
  end

endmodule
